// File: rtl/flash_read_ctrl_if.sv
// Bus bundle between the SPI-flash read master and its surroundings.
// The master modport is the controller's view; slave is the testbench/consumer view.
interface flash_read_ctrl_if;
   logic        key_flag;
   logic [23:0] rd_addr;
   logic        miso;
   logic        sck;
   logic        cs_n;
   logic        mosi;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        busy;
   logic        rd_done;

   modport master (
      input  key_flag, rd_addr, miso,
      output sck, cs_n, mosi, rd_data, rd_valid, busy, rd_done
   );

   modport slave (
      output key_flag, rd_addr, miso,
      input  sck, cs_n, mosi, rd_data, rd_valid, busy, rd_done
   );
endinterface

// File: rtl/flash_read_ctrl.sv
// SPI-flash read master (mode 0): sends READ + 24-bit address, then clocks RD_LEN bytes in.
// Every bus output is registered and computed from the next-state/counter values.
//
// state | meaning
// IDLE  | cs_n high, waiting for key_flag
// SETUP | one slot with cs_n low, sck idle
// CMD   | one slot shifting RD_CMD out
// ADDR  | three slots shifting addr[23:16], [15:8], [7:0]
// DATA  | RD_LEN slots shifting bytes in from miso
// HOLD  | one slot with cs_n low; rd_done strobes on its last cycle
module flash_read_ctrl #(
   parameter int unsigned RD_LEN = 16,
   parameter logic [7:0]  RD_CMD = 8'h03
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   flash_read_ctrl_if.master   bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      CMD   = 3'd2,
      ADDR  = 3'd3,
      DATA  = 3'd4,
      HOLD  = 3'd5
   } state_t;

   localparam logic [7:0] LAST_DATA = 8'(RD_LEN - 1);

   state_t      state_q, state_d;
   logic [4:0]  cnt_clk_q, cnt_clk_d;
   logic [7:0]  cnt_byte_q, cnt_byte_d;
   logic [23:0] addr_q;
   logic [7:0]  shift_q;
   logic        sck_q, cs_n_q, mosi_q, rd_valid_q, busy_q, rd_done_q;
   logic [7:0]  rd_data_q;

   logic        slot_end;
   logic        shifting_d;
   logic [7:0]  tx_byte;
   logic        tx_bit;

   always_comb begin
      state_d    = state_q;
      cnt_clk_d  = '0;
      cnt_byte_d = cnt_byte_q;
      slot_end   = (cnt_clk_q == 5'd31);
      if (state_q == IDLE) begin
         cnt_byte_d = '0;
         if (bus.key_flag) state_d = SETUP;
      end else begin
         cnt_clk_d = cnt_clk_q + 5'd1;
         if (slot_end) begin
            cnt_byte_d = '0;
            case (state_q)
               SETUP:   state_d = CMD;
               CMD:     state_d = ADDR;
               ADDR: begin
                  if (cnt_byte_q == 8'd2) state_d = DATA;
                  else                    cnt_byte_d = cnt_byte_q + 8'd1;
               end
               DATA: begin
                  if (cnt_byte_q == LAST_DATA) state_d = HOLD;
                  else                         cnt_byte_d = cnt_byte_q + 8'd1;
               end
               HOLD:    state_d = IDLE;
               default: state_d = IDLE;
            endcase
         end
      end
   end

   // Byte on the wire for the upcoming cycle; DATA/SETUP/HOLD/IDLE drive zeros.
   always_comb begin
      tx_byte = 8'h00;
      case (state_d)
         CMD: tx_byte = RD_CMD;
         ADDR: begin
            case (cnt_byte_d)
               8'd0:    tx_byte = addr_q[23:16];
               8'd1:    tx_byte = addr_q[15:8];
               default: tx_byte = addr_q[7:0];
            endcase
         end
         default: tx_byte = 8'h00;
      endcase
      tx_bit     = tx_byte[3'd7 - cnt_clk_d[4:2]];
      shifting_d = (state_d == CMD) || (state_d == ADDR) || (state_d == DATA);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= IDLE;
         cnt_clk_q  <= '0;
         cnt_byte_q <= '0;
         addr_q     <= '0;
         shift_q    <= '0;
         sck_q      <= 1'b0;
         cs_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         rd_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_clk_q  <= cnt_clk_d;
         cnt_byte_q <= cnt_byte_d;
         cs_n_q     <= (state_d == IDLE);
         busy_q     <= (state_d != IDLE);
         sck_q      <= shifting_d & cnt_clk_d[1];
         mosi_q     <= tx_bit;
         // rd_done lands on the final HOLD cycle so a coincident key_flag is not in IDLE
         rd_done_q  <= (state_d == HOLD) && (cnt_clk_d == 5'd31);
         rd_valid_q <= 1'b0;
         if (state_q == IDLE && bus.key_flag) addr_q <= bus.rd_addr;
         if (state_q == DATA && cnt_clk_q[1:0] == 2'd2) begin
            shift_q <= {shift_q[6:0], bus.miso};
            if (cnt_clk_q[4:2] == 3'd7) begin
               rd_data_q  <= {shift_q[6:0], bus.miso};
               rd_valid_q <= 1'b1;
            end
         end
      end
   end

   assign bus.sck      = sck_q;
   assign bus.cs_n     = cs_n_q;
   assign bus.mosi     = mosi_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.busy     = busy_q;
   assign bus.rd_done  = rd_done_q;

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Scoreboard bench: a flash memory model answers the DUT over SPI, expected bytes are queued
// at start time and popped by a monitor on every rd_valid; framing is checked on cs_n.
module tb_flash_read_ctrl;
   localparam int RD_LEN  = 16;
   localparam int TXN_LEN = (6 + RD_LEN) * 32;

   logic sys_clk = 1'b0;
   logic sys_rst_n = 1'b0;
   always #5 sys_clk = ~sys_clk;

   flash_read_ctrl_if bus();
   flash_read_ctrl_if if1();

   flash_read_ctrl #(.RD_LEN(RD_LEN), .RD_CMD(8'h03)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus.master));
   flash_read_ctrl #(.RD_LEN(1), .RD_CMD(8'h03)) dut1 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if1.master));

   assign if1.miso = 1'b1;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0]  mem [256];
   logic [7:0]  exp_data [$];
   logic [31:0] exp_hdr  [$];
   int outstanding = 0;
   int n_started = 0;
   int n_done = 0;
   bit abort_pend = 0;
   bit gap_chk = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Flash model: decode header on sck rise, drive next data bit on sck fall.
   int   bitcnt = 0;
   logic [31:0] hdr = '0;
   logic sck_prev = 1'b0;
   initial bus.miso = 1'b0;
   always @(negedge sys_clk) begin
      if (bus.cs_n) begin
         bitcnt = 0;
         bus.miso = 1'b0;
         sck_prev = 1'b0;
      end else begin
         if (bus.sck && !sck_prev) begin
            if (bitcnt < 32) hdr = {hdr[30:0], bus.mosi};
            bitcnt++;
            if (bitcnt == 32) begin
               if (exp_hdr.size() == 0) chk("hdr_unexpected", hdr, 32'hFFFFFFFF);
               else chk("cmd_addr_hdr", hdr, exp_hdr.pop_front());
            end
         end else if (!bus.sck && sck_prev && bitcnt >= 32) begin
            int idx;
            logic [7:0] b;
            idx = bitcnt - 32;
            b = mem[8'(hdr[7:0] + 8'(idx / 8))];
            bus.miso = b[7 - (idx % 8)];
         end
         sck_prev = bus.sck;
      end
   end

   // Monitor: data scoreboard, rd_done accounting, cs_n framing.
   int cyc = 0, last_v = 0, nbytes = 0, lo = 0, hi = 0;
   logic cs_prev = 1'b1, done_prev = 1'b0;
   always @(negedge sys_clk) begin
      cyc++;
      if (bus.rd_valid) begin
         if (exp_data.size() == 0) chk("rd_valid_unexpected", 1, 0);
         else chk("rd_data", 32'(bus.rd_data), 32'(exp_data.pop_front()));
         if (nbytes > 0) chk("valid_spacing", cyc - last_v, 32);
         last_v = cyc;
         nbytes++;
      end
      if (bus.rd_done) begin
         if (outstanding == 0) chk("rd_done_unexpected", 1, 0);
         else begin
            chk("busy_at_done", 32'(bus.busy), 1);
            outstanding--;
            n_done++;
         end
      end
      if (!bus.cs_n) begin
         if (cs_prev) begin
            if (gap_chk) begin
               chk("cs_gap", hi, 1);
               gap_chk = 0;
            end
            lo = 0;
            nbytes = 0;
         end
         lo++;
         hi = 0;
      end else begin
         if (!cs_prev) begin
            if (abort_pend) abort_pend = 0;
            else begin
               chk("cs_low_len", lo, TXN_LEN);
               chk("bytes_per_txn", nbytes, RD_LEN);
               chk("done_before_csn", 32'(done_prev), 1);
            end
         end
         hi++;
      end
      cs_prev = bus.cs_n;
      done_prev = bus.rd_done;
   end

   task automatic start(input logic [23:0] a, input bit gap);
      @(posedge sys_clk); #1;
      bus.key_flag = 1'b1;
      bus.rd_addr = a;
      gap_chk = gap;
      exp_hdr.push_back({8'h03, a});
      for (int i = 0; i < RD_LEN; i++) exp_data.push_back(mem[8'(a[7:0] + 8'(i))]);
      outstanding++;
      n_started++;
      @(posedge sys_clk); #1;
      bus.key_flag = 1'b0;
      bus.rd_addr = 24'($urandom);
   endtask

   task automatic pulse_only();
      @(posedge sys_clk); #1;
      bus.key_flag = 1'b1;
      bus.rd_addr = 24'($urandom);
      @(posedge sys_clk); #1;
      bus.key_flag = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge sys_clk);
         if (bus.rd_done) begin
            seen = 1;
            break;
         end
      end
      chk("done_timeout", 32'(seen), 1);
   endtask

   initial begin
      bus.key_flag = 1'b0;
      bus.rd_addr = '0;
      if1.key_flag = 1'b0;
      if1.rd_addr = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[8'h25] = 8'hA5;
      mem[8'h26] = 8'h3C;

      #12;
      chk("rst_cs_n", 32'(bus.cs_n), 1);
      chk("rst_sck", 32'(bus.sck), 0);
      chk("rst_mosi", 32'(bus.mosi), 0);
      chk("rst_rd_data", 32'(bus.rd_data), 0);
      chk("rst_outs", {29'd0, bus.rd_valid, bus.busy, bus.rd_done}, 0);
      #11 sys_rst_n = 1'b1;
      repeat (3) @(negedge sys_clk);
      chk("idle_cs_n", 32'(bus.cs_n), 1);

      // Fixed address with known first bytes
      start(24'h000425, 0);
      wait_done();
      repeat (3) @(negedge sys_clk);

      // Stray key_flag during ADDR and during DATA
      start(24'($urandom), 0);
      repeat (80) @(posedge sys_clk);
      pulse_only();
      repeat (300) @(posedge sys_clk);
      pulse_only();
      wait_done();
      repeat (5) @(negedge sys_clk);

      // Reset in the middle of byte 5
      start(24'($urandom), 0);
      repeat ((5 + 5) * 32 + 12) @(posedge sys_clk);
      #3;
      abort_pend = 1;
      sys_rst_n = 1'b0;
      #1;
      chk("abort_cs_n", 32'(bus.cs_n), 1);
      chk("abort_sck", 32'(bus.sck), 0);
      chk("abort_busy", 32'(bus.busy), 0);
      chk("abort_done", 32'(bus.rd_done), 0);
      exp_data.delete();
      outstanding = 0;
      n_started--;
      repeat (2) @(negedge sys_clk);
      #2 sys_rst_n = 1'b1;
      repeat (3) @(negedge sys_clk);
      start(24'($urandom), 0);
      wait_done();

      // Random transactions with random idle gaps
      for (int t = 0; t < 6; t++) begin
         repeat ($urandom_range(1, 20)) @(negedge sys_clk);
         start(24'($urandom), 0);
         wait_done();
      end

      // Back-to-back: start in the cycle right after rd_done
      start(24'($urandom), 0);
      wait_done();
      start(24'($urandom), 1);
      wait_done();
      repeat (5) @(negedge sys_clk);

      // RD_LEN=1 instance with miso tied high
      begin
         int lo1 = 0, nv = 0;
         logic [7:0] d1 = '0;
         bit seen1 = 0;
         @(posedge sys_clk); #1;
         if1.key_flag = 1'b1;
         if1.rd_addr = 24'h123456;
         @(posedge sys_clk); #1;
         if1.key_flag = 1'b0;
         for (int i = 0; i < 400; i++) begin
            @(negedge sys_clk);
            if (!if1.cs_n) lo1++;
            if (if1.rd_valid) begin
               nv++;
               d1 = if1.rd_data;
            end
            if (if1.rd_done) seen1 = 1;
            if (seen1 && if1.cs_n) break;
         end
         chk("len1_done", 32'(seen1), 1);
         chk("len1_cs_low", lo1, 224);
         chk("len1_valid_count", nv, 1);
         chk("len1_data", 32'(d1), 32'hFF);
      end

      repeat (5) @(negedge sys_clk);
      chk("exp_data_left", exp_data.size(), 0);
      chk("exp_hdr_left", exp_hdr.size(), 0);
      chk("outstanding_done", outstanding, 0);
      chk("done_count", n_done, n_started);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
